// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-port register file.
//   rf_state_e      : clear sequencer states
//   RF_*_DEF        : default parameter values used by the top and sub-module
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned RF_DATA_W_DEF   = 16;
  localparam int unsigned RF_ADDR_W_DEF   = 4;
  localparam int unsigned RF_ZERO_REG_DEF = 0;
  localparam int unsigned RF_BYPASS_DEF   = 1;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks the array one entry per enabled cycle on request.
// Ports:
//   clk, rst     : clock, async active-high reset
//   en           : global enable, 0 stalls the sweep
//   clr_req      : start request, sampled only while idle
//   busy         : sweep in progress (registered)
//   clr_done     : 1-cycle pulse after the last entry is cleared (registered)
//   clr_we       : combinational clear strobe for the current entry
//   clr_addr     : entry being cleared this cycle
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RF_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        case (r_state)
          RF_IDLE: begin
            if (clr_req) begin
              r_state <= RF_CLEAR;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          RF_CLEAR: begin
            // Counter parks on the last index rather than wrapping
            if (r_cnt == LAST_IDX) begin
              r_state <= RF_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
          default: begin
            r_state <= RF_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign clr_done = r_done;
  assign clr_we   = en & (r_state == RF_CLEAR);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/register_file_mp.sv
// Dual-read / single-write register file with registered reads, optional
// write-to-read bypass, optional hardwired-zero entry 0 and a clear sweep.
// Ports:
//   clk, rst               : clock, async active-high reset
//   en                     : global enable (freezes array, read regs, sweep)
//   wr_en/wr_addr/wr_data  : write request, held until wr_ready
//   wr_ready               : combinational, low while a sweep runs
//   rd_en, rd_addr_a/b     : read request for both ports
//   rd_data_a/b, rd_valid  : registered read results, 1-cycle latency
//   clr_req, busy, clr_done: clear sweep handshake
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W_DEF,
  parameter int unsigned ADDR_W   = RF_ADDR_W_DEF,
  parameter int unsigned DEPTH    = 2 ** ADDR_W,
  parameter int unsigned ZERO_REG = RF_ZERO_REG_DEF,
  parameter int unsigned BYPASS   = RF_BYPASS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic              r_rd_valid;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_land;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Entry is backed by storage (in range and not the hardwired zero)
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  rf_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_done (clr_done),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign busy     = w_busy;
  assign wr_ready = ~w_busy;

  // Accepted write that actually lands in storage; also the only one bypassed
  assign w_wr_land = en & wr_en & ~w_busy & addr_live(wr_addr);

  // Read muxes; the clear strobe is deliberately not forwarded
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (addr_live(rd_addr_a)) begin
      if ((BYPASS != 0) && w_wr_land && (wr_addr == rd_addr_a)) w_rd_a = wr_data;
      else                                                      w_rd_a = r_mem[rd_addr_a];
    end
    if (addr_live(rd_addr_b)) begin
      if ((BYPASS != 0) && w_wr_land && (wr_addr == rd_addr_b)) w_rd_b = wr_data;
      else                                                      w_rd_b = r_mem[rd_addr_b];
    end
  end

  // Storage array; writes and clears never coincide since wr_ready is low while clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_land) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Registered read ports; data holds when no read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_rd_valid <= 1'b0;
    end else if (en && rd_en) begin
      r_rd_a     <= w_rd_a;
      r_rd_b     <= w_rd_b;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_data_a = r_rd_a;
  assign rd_data_b = r_rd_b;
  assign rd_valid  = r_rd_valid;

endmodule
